mult_arbiter: RTL and testbench

Round-robin arbiter that shares one registered signed fixed-point multiplier, Q(Ent,Frac), between NReq requesters.
- Each requester uses a valid/ready request port.
- Results return on a single shared response channel, tagged with the requester index, and honour backpressure.
- Sits between algorithm datapaths (filters, oscillators) and the single multiplier resource in the arithmetic cluster.

---
 rtl/mult_arb_pkg.sv | 17 +
 rtl/mult_arb_core.sv | 76 +++++++
 rtl/mult_arbiter.sv | 111 +++++++++++
 tb/tb_mult_arbiter.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared Q-format defaults and helpers for the round-robin multiplier arbiter.
package mult_arb_pkg;
  localparam int WIDTH = 32;
  localparam int ENT   = 9;
  localparam int FRAC  = 22;

  localparam logic [WIDTH-1:0] ONE     = 32'd1 << FRAC;
  localparam logic [WIDTH-1:0] MAX_POS = 32'h7FFF_FFFF;
  localparam logic [WIDTH-1:0] MAX_NEG = 32'h8000_0000;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/mult_arb_core.sv
// Result stage of the shared multiplier: multiplies the S1 operands and registers the Q-format slice.
// Optional saturation is enabled with the MULT_ARB_SAT_EN macro.
module mult_arb_core
  import mult_arb_pkg::*;
#(
  parameter int Width = WIDTH,
  parameter int Ent   = ENT,
  parameter int Frac  = FRAC,
  parameter int IdW   = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             v1_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic [IdW-1:0]   id_i,
  output logic             rsp_valid_o,
  output logic [Width-1:0] rsp_data_o,
  output logic [IdW-1:0]   rsp_id_o
`ifdef MULT_ARB_SAT_EN
  ,
  output logic             sat_o
`endif
);

  logic signed [2*Width-1:0] prod_s;
  logic [Width-1:0]          res_s;
  logic                      sat_s;
  logic                      unused_prod_s;

  assign prod_s        = $signed(a_i) * $signed(b_i);
  assign unused_prod_s = ^prod_s;

`ifdef MULT_ARB_SAT_EN
  logic [2*Width-1-(2*Frac+Ent):0] upper_s;
  assign upper_s = prod_s[2*Width-1 : 2*Frac+Ent];

  // Clamp when the bits above the result slice are not a pure sign extension.
  always_comb begin
    sat_s = !((&upper_s) || (~|upper_s));
    res_s = prod_s[2*Frac+Ent -: Width];
    if (sat_s) begin
      res_s = prod_s[2*Width-1] ? {1'b1, {(Width-1){1'b0}}} : {1'b0, {(Width-1){1'b1}}};
    end else begin
      res_s = prod_s[2*Frac+Ent -: Width];
    end
  end
`else
  assign res_s = prod_s[2*Frac+Ent -: Width];
  assign sat_s = 1'b0;
`endif

  // Result register; loads whenever the response slot is free.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_id_o    <= '0;
`ifdef MULT_ARB_SAT_EN
      sat_o       <= 1'b0;
`endif
    end else if (en_i) begin
      rsp_valid_o <= v1_i;
      rsp_data_o  <= res_s;
      rsp_id_o    <= id_i;
`ifdef MULT_ARB_SAT_EN
      sat_o       <= sat_s;
`endif
    end
  end

  logic unused_sat_s;
  assign unused_sat_s = sat_s;

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin arbiter sharing one registered Q(Ent,Frac) multiplier between NReq requesters.
// Define MULT_ARB_SAT_EN to saturate results and expose sat_o.
module mult_arbiter
  import mult_arb_pkg::*;
#(
  parameter int Width = WIDTH,
  parameter int Ent   = ENT,
  parameter int Frac  = FRAC,
  parameter int NReq  = 4,
  parameter int IdW   = clog2(NReq)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [NReq-1:0]       req_valid_i,
  input  logic [NReq*Width-1:0] req_a_i,
  input  logic [NReq*Width-1:0] req_b_i,
  output logic [NReq-1:0]       req_ready_o,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [Width-1:0]      rsp_data_o,
  output logic [IdW-1:0]        rsp_id_o
`ifdef MULT_ARB_SAT_EN
  ,
  output logic                  sat_o
`endif
);

  localparam int CW = IdW + 1;

  logic [IdW-1:0]   ptr_r;
  logic [IdW-1:0]   ptr_nxt_s;
  logic [IdW-1:0]   gnt_idx_s;
  logic             gnt_found_s;
  logic             hit_s;
  logic [CW-1:0]    cand_s;
  logic             s2_free_s;
  logic             s1_free_s;
  logic             accept_s;
  logic             v1_r;
  logic [Width-1:0] a1_r;
  logic [Width-1:0] b1_r;
  logic [IdW-1:0]   id1_r;
  logic [Width-1:0] a_sel_s;
  logic [Width-1:0] b_sel_s;

  assign s2_free_s = !rsp_valid_o || rsp_ready_i;
  assign s1_free_s = !v1_r || s2_free_s;

  // Round-robin search: first valid requester at or after the pointer, wrapping modulo NReq.
  always_comb begin
    gnt_found_s = 1'b0;
    gnt_idx_s   = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < NReq; i++) begin
      cand_s      = CW'(ptr_r) + CW'(i);
      cand_s      = (cand_s >= CW'(NReq)) ? cand_s - CW'(NReq) : cand_s;
      hit_s       = !gnt_found_s && req_valid_i[cand_s[IdW-1:0]];
      gnt_idx_s   = hit_s ? cand_s[IdW-1:0] : gnt_idx_s;
      gnt_found_s = gnt_found_s | hit_s;
    end
  end

  assign ptr_nxt_s   = (gnt_idx_s == IdW'(NReq - 1)) ? '0 : gnt_idx_s + IdW'(1);
  assign accept_s    = gnt_found_s && s1_free_s;
  assign req_ready_o = (rst_ni && accept_s) ? (NReq'(1) << gnt_idx_s) : '0;
  assign a_sel_s     = req_a_i[gnt_idx_s*Width +: Width];
  assign b_sel_s     = req_b_i[gnt_idx_s*Width +: Width];

  // Operand stage and arbitration pointer; both frozen while the pipeline is stalled.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_r  <= 1'b0;
      a1_r  <= '0;
      b1_r  <= '0;
      id1_r <= '0;
      ptr_r <= '0;
    end else if (s1_free_s) begin
      v1_r  <= accept_s;
      a1_r  <= a_sel_s;
      b1_r  <= b_sel_s;
      id1_r <= gnt_idx_s;
      if (accept_s) begin
        ptr_r <= ptr_nxt_s;
      end
    end
  end

  mult_arb_core #(
    .Width(Width),
    .Ent  (Ent),
    .Frac (Frac),
    .IdW  (IdW)
  ) u_core (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (s2_free_s),
    .v1_i       (v1_r),
    .a_i        (a1_r),
    .b_i        (b1_r),
    .id_i       (id1_r),
    .rsp_valid_o(rsp_valid_o),
    .rsp_data_o (rsp_data_o),
    .rsp_id_o   (rsp_id_o)
`ifdef MULT_ARB_SAT_EN
    ,
    .sat_o      (sat_o)
`endif
  );

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: random and directed traffic against a queue-based reference model.
module tb_mult_arbiter;
  import mult_arb_pkg::*;

  localparam int NREQ = 4;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic [3:0]    req_valid_i;
  logic [127:0]  req_a_i;
  logic [127:0]  req_b_i;
  logic [3:0]    req_ready_o;
  logic          rsp_valid_o;
  logic          rsp_ready_i;
  logic [31:0]   rsp_data_o;
  logic [1:0]    rsp_id_o;
`ifdef MULT_ARB_SAT_EN
  logic          sat_o;
`endif

  mult_arbiter dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_valid_i(req_valid_i),
    .req_a_i    (req_a_i),
    .req_b_i    (req_b_i),
    .req_ready_o(req_ready_o),
    .rsp_valid_o(rsp_valid_o),
    .rsp_ready_i(rsp_ready_i),
    .rsp_data_o (rsp_data_o),
    .rsp_id_o   (rsp_id_o)
`ifdef MULT_ARB_SAT_EN
    ,
    .sat_o      (sat_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int          id;
    logic [31:0] data;
    logic        sat;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ptr_m = 0;
  int   cyc   = 0;
  bit   rst_seen = 1'b0;
  int   gcount[4];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: full product, floor-divide by 2^FRAC, then wrap or clamp to 32-bit signed.
  function automatic exp_t ref_mul(int id, logic [31:0] a, logic [31:0] b, int c);
    longint p, r;
    exp_t   e;
    p      = longint'($signed(a)) * longint'($signed(b));
    r      = p >>> FRAC;
    e.id   = id;
    e.cyc  = c;
    e.sat  = 1'b0;
    e.data = r[31:0];
`ifdef MULT_ARB_SAT_EN
    if (r > 64'sd2147483647) begin
      e.data = MAX_POS;
      e.sat  = 1'b1;
    end else if (r < -64'sd2147483648) begin
      e.data = MAX_NEG;
      e.sat  = 1'b1;
    end
`endif
    return e;
  endfunction

  function automatic logic [3:0] rr_pick(logic [3:0] v, int start);
    for (int k = 0; k < NREQ; k++) begin
      int idx;
      idx = (start + k) % NREQ;
      if (v[idx]) return 4'b0001 << idx;
    end
    return 4'b0000;
  endfunction

  function automatic logic [31:0] rnd_op();
    int t;
    t = $urandom;
    return 32'(t >>> $urandom_range(0, 14));
  endfunction

  // Model: predicts grants and response validity, pushes expected results on acceptance.
  always @(negedge clk_i) begin
    logic [3:0] exp_rdy;
    cyc++;
    if (!rst_ni) begin
      chk("ready_in_reset", req_ready_o, 4'b0000);
      exp_q.delete();
      ptr_m    = 0;
      rst_seen = 1'b1;
    end else begin
      if (rst_seen) begin
        chk("reset_rsp_valid", rsp_valid_o, 1'b0);
        chk("reset_rsp_data", rsp_data_o, 32'h0);
        chk("reset_rsp_id", rsp_id_o, 2'd0);
        rst_seen = 1'b0;
      end
      chk("rsp_valid", rsp_valid_o, (exp_q.size() > 0) && (exp_q[0].cyc <= cyc - 2));
      exp_rdy = (exp_q.size() < 2 || rsp_ready_i) ? rr_pick(req_valid_i, ptr_m) : 4'b0000;
      chk("req_ready", req_ready_o, exp_rdy);
      for (int k = 0; k < NREQ; k++) begin
        if (req_valid_i[k] && req_ready_o[k]) begin
          exp_q.push_back(ref_mul(k, req_a_i[k*32 +: 32], req_b_i[k*32 +: 32], cyc));
          ptr_m = (k + 1) % NREQ;
        end
      end
    end
  end

  // Monitor: pops and compares every response that transfers at the next edge.
  always @(negedge clk_i) begin
    exp_t e;
    #1;
    if (rst_ni && rsp_valid_o && rsp_ready_i) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL rsp_unexpected: got id %0d data %0h expected no response", rsp_id_o, rsp_data_o);
      end else begin
        tests--;
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id_o, e.id);
        chk("rsp_data", rsp_data_o, e.data);
`ifdef MULT_ARB_SAT_EN
        chk("rsp_sat", sat_o, e.sat);
`endif
      end
    end
  end

  task automatic step();
    logic [3:0] acc;
    @(negedge clk_i);
    acc = rst_ni ? (req_valid_i & req_ready_o) : 4'b0000;
    @(posedge clk_i);
    #1;
    for (int k = 0; k < NREQ; k++) begin
      if (acc[k]) begin
        req_valid_i[k] = 1'b0;
        gcount[k]++;
      end
    end
  endtask

  task automatic set_req(int k, logic [31:0] a, logic [31:0] b);
    req_valid_i[k]      = 1'b1;
    req_a_i[k*32 +: 32] = a;
    req_b_i[k*32 +: 32] = b;
  endtask

  initial begin
    logic [31:0] snap_data;
    logic [1:0]  snap_id;
    rst_ni      = 1'b0;
    req_valid_i = 4'b0000;
    req_a_i     = '0;
    req_b_i     = '0;
    rsp_ready_i = 1'b1;
    step();
    step();
    rst_ni = 1'b1;
    step();

    // Single requester: 1.5 * 2.0 = 3.0, two edges to the output.
    set_req(1, 32'h0060_0000, ONE << 1);
    step();
    step();
    chk("single_valid", rsp_valid_o, 1'b1);
    chk("single_data", rsp_data_o, 32'h00C0_0000);
    chk("single_id", rsp_id_o, 2'd1);
    step();

    // Sign: -1.0 * 0.5 = -0.5.
    set_req(2, 32'hFFC0_0000, 32'h0020_0000);
    step();
    step();
    chk("sign_data", rsp_data_o, 32'hFFE0_0000);
    step();

    // All requesters continuously valid.
    for (int k = 0; k < NREQ; k++) gcount[k] = 0;
    for (int n = 0; n < 40; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid_i[k]) set_req(k, rnd_op(), rnd_op());
      end
      step();
    end
    req_valid_i = 4'b0000;
    for (int k = 0; k < NREQ; k++) chk($sformatf("no_starve_%0d", k), gcount[k] >= 9, 1'b1);
    step();
    step();

    // Backpressure with two results in flight.
    rsp_ready_i = 1'b0;
    set_req(0, rnd_op(), rnd_op());
    set_req(3, rnd_op(), rnd_op());
    step();
    step();
    set_req(1, rnd_op(), rnd_op());
    snap_data = rsp_data_o;
    snap_id   = rsp_id_o;
    for (int n = 0; n < 5; n++) begin
      step();
      chk("bp_data_stable", rsp_data_o, snap_data);
      chk("bp_id_stable", rsp_id_o, snap_id);
      chk("bp_ready_low", req_ready_o, 4'b0000);
    end
    rsp_ready_i = 1'b1;
    for (int n = 0; n < 4; n++) step();

    // Overflow: 256.0 * 2.0.
    set_req(3, 32'h4000_0000, 32'h0080_0000);
    step();
    step();
`ifdef MULT_ARB_SAT_EN
    chk("ovf_data", rsp_data_o, MAX_POS);
    chk("ovf_sat", sat_o, 1'b1);
`else
    chk("ovf_data", rsp_data_o, 32'h8000_0000);
`endif
    step();

    // Random traffic with random backpressure.
    for (int n = 0; n < 300; n++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!req_valid_i[k] && ($urandom_range(0, 2) == 0)) set_req(k, rnd_op(), rnd_op());
      end
      rsp_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    rsp_ready_i = 1'b1;
    for (int n = 0; n < 12; n++) step();
    req_valid_i = 4'b0000;
    step();
    step();

    // Mid-operation reset with S1 and S2 both occupied.
    rsp_ready_i = 1'b0;
    set_req(0, rnd_op(), rnd_op());
    set_req(2, rnd_op(), rnd_op());
    step();
    step();
    rst_ni = 1'b0;
    step();
    rst_ni = 1'b1;
    rsp_ready_i = 1'b1;
    set_req(0, rnd_op(), rnd_op());
    set_req(2, rnd_op(), rnd_op());
    #1;
    chk("post_reset_valid", rsp_valid_o, 1'b0);
    chk("post_reset_grant", req_ready_o, 4'b0001);
    for (int n = 0; n < 4; n++) step();

    // Drain with a bounded wait.
    req_valid_i = 4'b0000;
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) step();
    step();
    chk("drained", exp_q.size(), 0);
    chk("idle_valid", rsp_valid_o, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
